firebird_lsu: RTL and testbench

FIREBIRD_LSU -- requirements
Module: firebird_lsu
Interface
REQ-001 Parameters: none; data/address width SHALL be `FIREBIRD_REG_SIZE (32) from firebird_defines.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset; asynchronous, active-low.
REQ-004 req_valid  in  1  execute stage presents a load/store.
REQ-005 req_ready  out  1  LSU idle and accepting; low doubles as core stall.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 req_addr  in  32  effective byte address.
REQ-009 req_wdata  in  32  store source (rs2 value).
REQ-010 req_rd  in  5  load destination register.
REQ-011 mem_req_valid / mem_req_ready  out / in  1 / 1  data-memory request handshake.
REQ-012 mem_we  out  1  request is a write.
REQ-013 mem_addr  out  32  word-aligned address ({req_addr[31:2],2'b00}).
REQ-014 mem_wstrb  out  4  byte-lane write enables.
REQ-015 mem_wdata  out  32  lane-replicated store data.
REQ-016 mem_rsp_valid  in  1  response strobe (loads and stores).
REQ-017 mem_rdata  in  32  read word.
REQ-018 mem_rsp_err  in  1  access fault, qualified by mem_rsp_valid.
REQ-019 wb_we / wb_waddr / wb_wdata  out  1 / 5 / 32  register-file write port.
REQ-020 exc_misalign / exc_access  out  1 / 1  one-cycle exception pulses.
Function
REQ-021 FSM states SHALL be IDLE, REQ, RESP, WB; req_ready=1 only in IDLE.
REQ-022 IDLE: on req_valid, capture all req_* fields; legal aligned op -> REQ.
REQ-023 Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0) or undefined funct3 (3'b011, 3'b11x; stores >3'b010) SHALL pulse exc_misalign next cycle, stay IDLE, issue no memory request.
REQ-024 REQ: mem_req_valid=1 with addr/we/wstrb/wdata held stable until sampled with mem_req_ready=1, then -> RESP.
REQ-025 RESP: mem_rsp_valid ignored in all other states; on mem_rsp_valid, store -> IDLE, load -> WB (capture extracted data); mem_rsp_err -> exc_access pulse, no writeback, -> IDLE.
REQ-026 WB: wb_we=1 for exactly one cycle with captured rd/data, then -> IDLE; wb_we SHALL be 0 when rd=0.
REQ-027 Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass.
REQ-028 Store: SB wstrb=4'b0001<<addr[1:0], data byte replicated x4; SH wstrb=4'b0011 or 4'b1100 by addr[1], half replicated x2; SW 4'b1111.
REQ-029 wb_we, mem_req_valid, exc_* SHALL be 0 outside their states; mem_wstrb=0 for loads.
REQ-030 Zero-wait memory (ready in REQ, rsp next cycle): load accepted cycle 0 writes back in cycle 3, req_ready high again cycle 4; store done in 3 cycles.
Reset
REQ-031 reset_n low SHALL force IDLE and all outputs 0 except req_ready=1, asynchronously, aborting any in-flight request.
REQ-032 A response arriving after reset release SHALL be ignored (state IDLE).
Structure
REQ-033 funct3 codes and FSM state encodings SHALL live in firebird_defines.
REQ-034 Combinational sub-module firebird_lsu_align SHALL hold load extract/extend and store lane/strobe generation.
Verification
REQ-035 LB addr 0x103, rdata 0x80FF_1234 -> wb_wdata 0xFFFF_FF80, wb_waddr=rd, wb_we one cycle in cycle 3.
REQ-036 SH addr 0x202, wdata 0x0000_ABCD -> mem_addr 0x200, wstrb 4'b1100, mem_wdata 0xABCD_ABCD, no wb_we.
REQ-037 LW addr 0x101 -> exc_misalign pulse, mem_req_valid never asserted, req_ready stays 1.
REQ-038 mem_req_ready held low 5 cycles then rsp with mem_rsp_err=1 -> signals stable while stalled, exc_access pulse, wb_we=0.
REQ-039 reset_n dropped in RESP, then rsp pulse after release -> IDLE immediately, no writeback; LBU rd=0 -> wb_we stays 0.

---
 rtl/firebird_defines.sv | 40 ++++
 rtl/firebird_lsu_if.sv | 43 ++++
 rtl/firebird_lsu_align.sv | 44 ++++
 rtl/firebird_lsu.sv | 98 +++++++++
 tb/tb_firebird_lsu.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/firebird_defines.sv
// Shared widths, RV32I load/store width codes and LSU state encodings.
`ifndef FIREBIRD_REG_SIZE
`define FIREBIRD_REG_SIZE 32
`endif

package firebird_defines;

  localparam int REG_SIZE = `FIREBIRD_REG_SIZE;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_WB   = 2'd3
  } lsu_state_t;

  // True when funct3 is defined for the direction and the address is naturally aligned.
  function automatic logic op_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    if (we) begin
      ok = (f3 == F3_B) || ((f3 == F3_H) && !a[0]) || ((f3 == F3_W) && (a == 2'b00));
    end else begin
      case (f3)
        F3_B, F3_BU: ok = 1'b1;
        F3_H, F3_HU: ok = !a[0];
        F3_W:        ok = (a == 2'b00);
        default:     ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/firebird_lsu_if.sv
// Execute-stage request, data-memory bus and writeback/exception signals of the LSU.
interface firebird_lsu_if;
  import firebird_defines::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [2:0]          req_funct3;
  logic [REG_SIZE-1:0] req_addr;
  logic [REG_SIZE-1:0] req_wdata;
  logic [4:0]          req_rd;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_we;
  logic [REG_SIZE-1:0] mem_addr;
  logic [3:0]          mem_wstrb;
  logic [REG_SIZE-1:0] mem_wdata;
  logic                mem_rsp_valid;
  logic [REG_SIZE-1:0] mem_rdata;
  logic                mem_rsp_err;

  logic                wb_we;
  logic [4:0]          wb_waddr;
  logic [REG_SIZE-1:0] wb_wdata;
  logic                exc_misalign;
  logic                exc_access;

  // slave: the LSU itself; master: the surrounding core and memory.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err,
    output req_ready, mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output wb_we, wb_waddr, wb_wdata, exc_misalign, exc_access
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err,
    input  req_ready, mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  wb_we, wb_waddr, wb_wdata, exc_misalign, exc_access
  );
endinterface

// File: rtl/firebird_lsu_align.sv
// Byte-lane logic: store strobe/replication and load extract with sign/zero extension.
module firebird_lsu_align
  import firebird_defines::*;
(
  input  logic [2:0]          funct3,
  input  logic [1:0]          addr_lo,
  input  logic [REG_SIZE-1:0] wdata,
  input  logic [REG_SIZE-1:0] rdata,
  output logic [3:0]          wstrb,
  output logic [REG_SIZE-1:0] wdata_lane,
  output logic [REG_SIZE-1:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
    half_sel   = rdata[{addr_lo[1], 4'b0000} +: 16];
    sext       = !funct3[2];
    wstrb      = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    case (funct3[1:0])
      2'b00: begin
        wstrb      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{(REG_SIZE-8){sext & byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{(REG_SIZE-16){sext & half_sel[15]}}, half_sel};
      end
      default: begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/firebird_lsu.sv
// RV32I load/store unit: one outstanding access, IDLE -> REQ -> RESP (-> WB) sequencing.
//   state | meaning
//   IDLE  | accepting a request; rejects misaligned/undefined ops with exc_misalign
//   REQ   | presenting the memory request until mem_req_ready
//   RESP  | waiting for mem_rsp_valid
//   WB    | one-cycle register-file write of the extracted load data
module firebird_lsu
  import firebird_defines::*;
(
  input  logic          clk,
  input  logic          reset_n,
  firebird_lsu_if.slave bus
);

  lsu_state_t          state, state_nxt;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [REG_SIZE-1:0] addr_q;
  logic [REG_SIZE-1:0] wdata_q;
  logic [REG_SIZE-1:0] ld_data_q;
  logic [4:0]          rd_q;
  logic                exc_mis_q;
  logic                exc_acc_q;
  logic                req_legal;
  logic                in_req;
  logic                in_wb;
  logic [3:0]          lane_strb;
  logic [REG_SIZE-1:0] lane_wdata;
  logic [REG_SIZE-1:0] ld_ext;

  firebird_lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (bus.mem_rdata),
    .wstrb      (lane_strb),
    .wdata_lane (lane_wdata),
    .rdata_ext  (ld_ext)
  );

  assign req_legal = op_legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.req_valid && req_legal) state_nxt = ST_REQ;
      ST_REQ:  if (bus.mem_req_ready) state_nxt = ST_RESP;
      ST_RESP: if (bus.mem_rsp_valid) state_nxt = (we_q || bus.mem_rsp_err) ? ST_IDLE : ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      ld_data_q <= '0;
      exc_mis_q <= 1'b0;
      exc_acc_q <= 1'b0;
    end else begin
      exc_mis_q <= (state == ST_IDLE) && bus.req_valid && !req_legal;
      exc_acc_q <= (state == ST_RESP) && bus.mem_rsp_valid && bus.mem_rsp_err;
      if (state == ST_IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rd_q    <= bus.req_rd;
      end
      if (state == ST_RESP && bus.mem_rsp_valid) ld_data_q <= ld_ext;
    end
  end

  // Bus outputs are forced to zero outside their owning state so a reset leaves them all low.
  assign in_req            = (state == ST_REQ);
  assign in_wb             = (state == ST_WB);
  assign bus.req_ready     = (state == ST_IDLE);
  assign bus.mem_req_valid = in_req;
  assign bus.mem_we        = in_req && we_q;
  assign bus.mem_addr      = in_req ? {addr_q[REG_SIZE-1:2], 2'b00} : '0;
  assign bus.mem_wstrb     = (in_req && we_q) ? lane_strb : 4'b0000;
  assign bus.mem_wdata     = (in_req && we_q) ? lane_wdata : '0;
  assign bus.wb_we         = in_wb && (rd_q != 5'd0);
  assign bus.wb_waddr      = in_wb ? rd_q : 5'd0;
  assign bus.wb_wdata      = in_wb ? ld_data_q : '0;
  assign bus.exc_misalign  = exc_mis_q;
  assign bus.exc_access    = exc_acc_q;

endmodule

// File: tb/tb_firebird_lsu.sv
// Directed-vector scoreboard bench for firebird_lsu.
module tb_firebird_lsu;
  import firebird_defines::*;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    int          stall;
    logic        bad;
    logic [3:0]  x_wstrb;
    logic [31:0] x_mwdata;
    logic [31:0] x_wb;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mexp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wexp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  mexp_t mem_q[$];
  wexp_t wb_q[$];
  int    exc_q[$];
  vec_t  vecs[$];

  firebird_lsu_if bus ();

  firebird_lsu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a handshake, writeback or exception.
  mexp_t me;
  wexp_t we_e;
  int    ek;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (mem_q.size() == 0) check("mem_unexpected", 32'd1, 32'd0);
        else begin
          me = mem_q.pop_front();
          check("mem_we", {31'd0, bus.mem_we}, {31'd0, me.we});
          check("mem_addr", bus.mem_addr, me.addr);
          check("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, me.wstrb});
          if (me.we) check("mem_wdata", bus.mem_wdata, me.wdata);
        end
      end
      if (bus.wb_we) begin
        if (wb_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
        else begin
          we_e = wb_q.pop_front();
          check("wb_waddr", {27'd0, bus.wb_waddr}, {27'd0, we_e.rd});
          check("wb_wdata", bus.wb_wdata, we_e.data);
        end
      end
      if (bus.exc_misalign || bus.exc_access) begin
        if (exc_q.size() == 0) check("exc_unexpected", 32'd1, 32'd0);
        else begin
          ek = exc_q.pop_front();
          check("exc_kind", {30'd0, bus.exc_access, bus.exc_misalign}, (ek == 1) ? 32'd2 : 32'd1);
        end
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                              input logic err, input int stall, input logic bad, input logic [3:0] x_wstrb,
                              input logic [31:0] x_mwdata, input logic [31:0] x_wb);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
    v.err = err; v.stall = stall; v.bad = bad; v.x_wstrb = x_wstrb; v.x_mwdata = x_mwdata; v.x_wb = x_wb;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    mexp_t m;
    wexp_t w;
    logic  does_wb;
    does_wb = !v.we && !v.err && (v.rd != 5'd0);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_rd     = v.rd;
    if (v.bad) exc_q.push_back(0);
    else begin
      m.we = v.we; m.addr = {v.addr[31:2], 2'b00}; m.wstrb = v.x_wstrb; m.wdata = v.x_mwdata;
      mem_q.push_back(m);
      if (does_wb) begin
        w.rd = v.rd; w.data = v.x_wb;
        wb_q.push_back(w);
      end
      if (v.err) exc_q.push_back(1);
    end
    cyc();
    bus.req_valid = 1'b0;
    if (v.bad) begin
      check("misalign_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("misalign_no_mem", {31'd0, bus.mem_req_valid}, 32'd0);
      cyc();
      check("misalign_pulse_end", {31'd0, bus.exc_misalign}, 32'd0);
      check("misalign_no_mem2", {31'd0, bus.mem_req_valid}, 32'd0);
      return;
    end
    check("busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
    for (int i = 0; i < v.stall; i++) begin
      check("stall_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      check("stall_addr", bus.mem_addr, {v.addr[31:2], 2'b00});
      check("stall_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, v.x_wstrb});
      cyc();
    end
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    check("resp_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = v.rdata;
    bus.mem_rsp_err   = v.err;
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_err   = 1'b0;
    check("wb_we_slot", {31'd0, bus.wb_we}, {31'd0, does_wb});
    if (!v.we && !v.err) cyc();
    check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("idle_wb_off", {31'd0, bus.wb_we}, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mexp_t m;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_rd = '0; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata = '0; bus.mem_rsp_err = 1'b0;

    // we f3 addr wdata rd rdata err stall bad wstrb mwdata wbdata
    vecs.push_back(mk(0, F3_B,   32'h103, 32'h0,        5'd5,  32'h80FF_1234, 0, 0, 0, 4'b0000, 32'h0,         32'hFFFF_FF80));
    vecs.push_back(mk(1, F3_H,   32'h202, 32'h0000_ABCD, 5'd0, 32'h0,         0, 0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0));
    vecs.push_back(mk(0, F3_W,   32'h101, 32'h0,        5'd4,  32'h0,         0, 0, 1, 4'b0000, 32'h0,         32'h0));
    vecs.push_back(mk(0, F3_W,   32'h300, 32'h0,        5'd6,  32'h1234_5678, 1, 5, 0, 4'b0000, 32'h0,         32'h0));
    vecs.push_back(mk(0, F3_HU,  32'h502, 32'h0,        5'd7,  32'h8765_4321, 0, 0, 0, 4'b0000, 32'h0,         32'h0000_8765));
    vecs.push_back(mk(0, F3_H,   32'h500, 32'h0,        5'd8,  32'h1111_F00D, 0, 0, 0, 4'b0000, 32'h0,         32'hFFFF_F00D));
    vecs.push_back(mk(1, F3_B,   32'h601, 32'h0000_00A5, 5'd0, 32'h0,         0, 0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0));
    vecs.push_back(mk(1, F3_W,   32'h700, 32'hDEAD_BEEF, 5'd0, 32'h0,         0, 2, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(0, F3_W,   32'h800, 32'h0,        5'd31, 32'hCAFE_F00D, 0, 0, 0, 4'b0000, 32'h0,         32'hCAFE_F00D));
    vecs.push_back(mk(0, 3'b011, 32'h900, 32'h0,        5'd1,  32'h0,         0, 0, 1, 4'b0000, 32'h0,         32'h0));
    vecs.push_back(mk(1, 3'b100, 32'h904, 32'h0,        5'd0,  32'h0,         0, 0, 1, 4'b0000, 32'h0,         32'h0));
    vecs.push_back(mk(0, F3_H,   32'hA01, 32'h0,        5'd2,  32'h0,         0, 0, 1, 4'b0000, 32'h0,         32'h0));
    vecs.push_back(mk(0, F3_B,   32'hB00, 32'h0,        5'd3,  32'h0000_007F, 0, 0, 0, 4'b0000, 32'h0,         32'h0000_007F));
    vecs.push_back(mk(0, F3_BU,  32'hB02, 32'h0,        5'd9,  32'h00C3_0000, 0, 0, 0, 4'b0000, 32'h0,         32'h0000_00C3));
    vecs.push_back(mk(1, F3_H,   32'hC00, 32'h1234_5678, 5'd0, 32'h0,         0, 0, 0, 4'b0011, 32'h5678_5678, 32'h0));

    #12;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("rst_wb_we", {31'd0, bus.wb_we}, 32'd0);
    check("rst_exc", {30'd0, bus.exc_access, bus.exc_misalign}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting for a load response, then a stale response after release.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W; bus.req_addr = 32'hD00; bus.req_rd = 5'd10;
    m.we = 1'b0; m.addr = 32'hD00; m.wstrb = 4'b0000; m.wdata = 32'h0;
    mem_q.push_back(m);
    cyc();
    bus.req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    check("resp_state_busy", {31'd0, bus.req_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("async_rst_outputs", {29'd0, bus.mem_req_valid, bus.wb_we, bus.exc_access}, 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    cyc();
    bus.mem_rsp_valid = 1'b0;
    check("stale_rsp_wb", {31'd0, bus.wb_we}, 32'd0);
    check("stale_rsp_ready", {31'd0, bus.req_ready}, 32'd1);
    cyc();
    check("stale_rsp_wb2", {31'd0, bus.wb_we}, 32'd0);

    // LBU to x0 goes through WB but must never write.
    run_vec(mk(0, F3_BU, 32'h401, 32'h0, 5'd0, 32'h1234_5678, 0, 0, 0, 4'b0000, 32'h0, 32'h0));
    cyc();
    cyc();

    check("mem_q_drained", mem_q.size(), 32'd0);
    check("wb_q_drained", wb_q.size(), 32'd0);
    check("exc_q_drained", exc_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
